psg_register_file: RTL and testbench

Bus-side write interface and register file for the SN76489-compatible sound generator. It accepts byte writes from the system VIA and decodes the chip's latch/data byte protocol. It holds the eight internal registers: three 10-bit tone periods, three tone attenuations, the noise control and the noise attenuation. It drives the per-channel tone generators, the noise generator and the attenuators directly, and models the chip's READY handshake.

---
 rtl/psg_pkg.sv | 46 ++++
 rtl/psg_ready_timer.sv | 62 ++++++
 rtl/psg_register_file.sv | 153 +++++++++++++++
 tb/tb_psg_register_file.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared definitions for the SN76489-compatible sound generator register file.
// Register addresses are the 3-bit {channel, type} pair carried in a latch byte.
package psg_pkg;

    localparam int unsigned PSG_DATA_W  = 8;
    localparam int unsigned PSG_FREQ_W  = 10;
    localparam int unsigned PSG_ATT_W   = 4;
    localparam int unsigned PSG_NCTRL_W = 3;
    localparam int unsigned PSG_ADDR_W  = 3;

    typedef logic [PSG_ADDR_W-1:0] psg_addr_t;

    localparam psg_addr_t PSG_TONE0     = 3'd0;
    localparam psg_addr_t PSG_ATT0      = 3'd1;
    localparam psg_addr_t PSG_TONE1     = 3'd2;
    localparam psg_addr_t PSG_ATT1      = 3'd3;
    localparam psg_addr_t PSG_TONE2     = 3'd4;
    localparam psg_addr_t PSG_ATT2      = 3'd5;
    localparam psg_addr_t PSG_NOISE     = 3'd6;
    localparam psg_addr_t PSG_NOISE_ATT = 3'd7;

    localparam logic [PSG_ATT_W-1:0] PSG_ATT_OFF = 4'hF;

    typedef enum logic {
        PSG_IDLE = 1'b0,
        PSG_BUSY = 1'b1
    } psg_state_e;

    // One decoded bus write: target register and the payload bits it may use.
    typedef struct packed {
        logic      is_latch;
        psg_addr_t addr;
        logic [5:0] value;
    } psg_wr_t;

    // Latch bytes carry their own address; data bytes reuse the last latched one.
    function automatic psg_wr_t psg_decode(input logic [PSG_DATA_W-1:0] wr_byte,
                                           input psg_addr_t             latch_addr);
        psg_wr_t w;
        w.is_latch = wr_byte[7];
        w.addr     = wr_byte[7] ? psg_addr_t'(wr_byte[6:4]) : latch_addr;
        w.value    = wr_byte[5:0];
        return w;
    endfunction

endpackage

// File: rtl/psg_ready_timer.sv
// READY handshake timer: IDLE/BUSY state plus a down-counter that holds BUSY
// for exactly READY_CYCLES cycles after each accept.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   accept_i       one-cycle accept pulse (only honoured in IDLE)
//   ready_o        high in IDLE
//   busy_o         high in BUSY
module psg_ready_timer
    import psg_pkg::*;
#(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic accept_i,
    output logic ready_o,
    output logic busy_o
);

    localparam int unsigned CNT_W = $clog2(READY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READY_CYCLES - 1);

    psg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PSG_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the BUSY cycle that sees zero is the last low cycle of ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PSG_IDLE: begin
                if (accept_i) begin
                    state_d = PSG_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            PSG_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = PSG_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = PSG_IDLE;
        endcase
    end

    assign ready_o = (state_q == PSG_IDLE);
    assign busy_o  = (state_q == PSG_BUSY);

endmodule

// File: rtl/psg_register_file.sv
// Bus-side write interface and register file of the SN76489-compatible sound
// generator: decodes latch/data bytes into three tone periods, four
// attenuations and the noise control, and models the chip's READY handshake.
// Optional macro PSG_WE_SYNC_EN: pass we_n/data through a two-flop
// synchroniser before edge detection (adds 2 cycles of latency).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   we_n, data[7:0]       write strobe (falling edge) and write byte
//   ready                 high when idle, low while absorbing a write
//   freq0..freq2[9:0]     tone half-periods
//   att0..att3[3:0]       attenuation, tones 0-2 and noise (15 = off)
//   noise_ctrl[2:0]       bit 2 white/periodic, bits 1:0 shift rate
//   noise_rst             one-cycle pulse on each noise control write
module psg_register_file
    import psg_pkg::*;
#(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we_n,
    input  logic [PSG_DATA_W-1:0]  data,
    output logic                   ready,
    output logic [PSG_FREQ_W-1:0]  freq0,
    output logic [PSG_FREQ_W-1:0]  freq1,
    output logic [PSG_FREQ_W-1:0]  freq2,
    output logic [PSG_ATT_W-1:0]   att0,
    output logic [PSG_ATT_W-1:0]   att1,
    output logic [PSG_ATT_W-1:0]   att2,
    output logic [PSG_ATT_W-1:0]   att3,
    output logic [PSG_NCTRL_W-1:0] noise_ctrl,
    output logic                   noise_rst
);

    logic                  we_n_s;
    logic [PSG_DATA_W-1:0] data_s;

`ifdef PSG_WE_SYNC_EN
    logic [1:0]            we_sync_q;
    logic [PSG_DATA_W-1:0] data_s1_q, data_s2_q;

    // Two-flop synchroniser; strobe stages idle high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_sync_q <= 2'b11;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            we_sync_q <= {we_sync_q[0], we_n};
            data_s1_q <= data;
            data_s2_q <= data_s1_q;
        end
    end

    assign we_n_s = we_sync_q[1];
    assign data_s = data_s2_q;
`else
    assign we_n_s = we_n;
    assign data_s = data;
`endif

    logic    we_n_q;
    logic    accept;
    logic    ready_c;
    logic    busy_c;
    psg_wr_t wr_c;

    logic [2:0][PSG_FREQ_W-1:0] freq_q, freq_d;
    logic [3:0][PSG_ATT_W-1:0]  att_q, att_d;
    logic [PSG_NCTRL_W-1:0]     noise_ctrl_q, noise_ctrl_d;
    psg_addr_t                  latch_addr_q, latch_addr_d;
    logic                       noise_rst_q, noise_rst_d;

    // Falling edges seen while BUSY are dropped without effect
    assign accept = we_n_q & ~we_n_s & ready_c;

    psg_ready_timer #(
        .READY_CYCLES (READY_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .accept_i (accept),
        .ready_o  (ready_c),
        .busy_o   (busy_c)
    );

    // Register file and strobe history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_n_q       <= 1'b1;
            freq_q       <= '0;
            att_q        <= {4{PSG_ATT_OFF}};
            noise_ctrl_q <= '0;
            latch_addr_q <= PSG_TONE0;
            noise_rst_q  <= 1'b0;
        end else begin
            we_n_q       <= we_n_s;
            freq_q       <= freq_d;
            att_q        <= att_d;
            noise_ctrl_q <= noise_ctrl_d;
            latch_addr_q <= latch_addr_d;
            noise_rst_q  <= noise_rst_d;
        end
    end

    // Write decode: latch bytes set the low nibble, data bytes the upper six bits
    always_comb begin
        freq_d       = freq_q;
        att_d        = att_q;
        noise_ctrl_d = noise_ctrl_q;
        latch_addr_d = latch_addr_q;
        noise_rst_d  = 1'b0;
        wr_c         = psg_decode(data_s, latch_addr_q);

        if (accept) begin
            if (wr_c.is_latch) begin
                latch_addr_d = wr_c.addr;
            end
            if (wr_c.addr[0]) begin
                att_d[wr_c.addr[2:1]] = wr_c.value[3:0];
            end else if (wr_c.addr == PSG_NOISE) begin
                noise_ctrl_d = wr_c.value[2:0];
                noise_rst_d  = 1'b1;
            end else begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (wr_c.addr[2:1] == 2'(i)) begin
                        if (wr_c.is_latch) begin
                            freq_d[i][3:0] = wr_c.value[3:0];
                        end else begin
                            freq_d[i][9:4] = wr_c.value;
                        end
                    end
                end
            end
        end
    end

    assign ready      = ready_c;
    assign freq0      = freq_q[0];
    assign freq1      = freq_q[1];
    assign freq2      = freq_q[2];
    assign att0       = att_q[0];
    assign att1       = att_q[1];
    assign att2       = att_q[2];
    assign att3       = att_q[3];
    assign noise_ctrl = noise_ctrl_q;
    assign noise_rst  = noise_rst_q;

    // busy is implied by ~ready here; kept for timer completeness
    logic unused_c;
    assign unused_c = busy_c;

endmodule

// File: tb/tb_psg_register_file.sv
// Self-checking bench for psg_register_file with a behavioural model of the
// latch/data byte protocol and the READY timing.
module tb_psg_register_file;

    localparam int unsigned RC = 32;

    logic       clk;
    logic       reset_n;
    logic       we_n;
    logic [7:0] data;
    logic       ready;
    logic [9:0] freq0, freq1, freq2;
    logic [3:0] att0, att1, att2, att3;
    logic [2:0] noise_ctrl;
    logic       noise_rst;

    psg_register_file #(.READY_CYCLES(RC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_n       (we_n),
        .data       (data),
        .ready      (ready),
        .freq0      (freq0),
        .freq1      (freq1),
        .freq2      (freq2),
        .att0       (att0),
        .att1       (att1),
        .att2       (att2),
        .att3       (att3),
        .noise_ctrl (noise_ctrl),
        .noise_rst  (noise_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] dut_freq [3];
    logic [3:0] dut_att  [4];
    assign dut_freq[0] = freq0;
    assign dut_freq[1] = freq1;
    assign dut_freq[2] = freq2;
    assign dut_att[0]  = att0;
    assign dut_att[1]  = att1;
    assign dut_att[2]  = att2;
    assign dut_att[3]  = att3;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [9:0] m_freq [3];
    logic [3:0] m_att  [4];
    logic [2:0] m_nctrl;
    int         m_ch;
    bit         m_is_att;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_freq[i] = 10'd0;
        for (int i = 0; i < 4; i++) m_att[i] = 4'hF;
        m_nctrl  = 3'd0;
        m_ch     = 0;
        m_is_att = 1'b0;
    endfunction

    // Apply one accepted byte; returns 1 when it reseeds the noise LFSR.
    function automatic bit model_write(input logic [7:0] d);
        int  v;
        bit  pulse;
        v     = int'(d);
        pulse = 1'b0;
        if (v >= 128) begin
            m_ch     = (v / 32) % 4;
            m_is_att = ((v / 16) % 2) == 1;
        end
        if (m_is_att) begin
            m_att[m_ch] = 4'(v % 16);
        end else if (m_ch == 3) begin
            m_nctrl = 3'(v % 8);
            pulse   = 1'b1;
        end else if (v >= 128) begin
            m_freq[m_ch] = 10'((int'(m_freq[m_ch]) / 16) * 16 + v % 16);
        end else begin
            m_freq[m_ch] = 10'((v % 64) * 16 + int'(m_freq[m_ch]) % 16);
        end
        return pulse;
    endfunction

    // Drive one falling edge; returns one cycle after the detection cycle.
    task automatic pulse_we(input logic [7:0] d);
        @(posedge clk); #1;
        data = d;
        we_n = 1'b0;
        @(posedge clk); #1;
        we_n = 1'b1;
    endtask

    // Cycles until ready is seen high, bounded.
    task automatic wait_ready(output int k);
        k = 0;
        while (!ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if ({freq0, freq1, freq2} !== 30'd0) begin bad++; $display("FAIL reset_freq got=%h %h %h exp=0", freq0, freq1, freq2); end
        total++; if ({att0, att1, att2, att3} !== 16'hFFFF) begin bad++; $display("FAIL reset_att got=%h exp=ffff", {att0, att1, att2, att3}); end
        total++; if (noise_ctrl !== 3'd0) begin bad++; $display("FAIL reset_nctrl got=%0d exp=0", noise_ctrl); end
        total++; if (noise_rst !== 1'b0) begin bad++; $display("FAIL reset_nrst got=%b exp=0", noise_rst); end
    endtask

    task automatic test_tone();
        int k;
        void'(model_write(8'h8E));
        pulse_we(8'h8E);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL tone_ready_low got=%b exp=0", ready); end
        total++; if (freq0 !== 10'h00E) begin bad++; $display("FAIL tone_latch got=%h exp=00e", freq0); end
        wait_ready(k);
        total++; if (k != int'(RC)) begin bad++; $display("FAIL tone_ready_len1 got=%0d exp=%0d", k, RC); end
        void'(model_write(8'h0F));
        pulse_we(8'h0F);
        total++; if (freq0 !== 10'h0FE) begin bad++; $display("FAIL tone_data got=%h exp=0fe", freq0); end
        wait_ready(k);
        total++; if (k != int'(RC)) begin bad++; $display("FAIL tone_ready_len2 got=%0d exp=%0d", k, RC); end
    endtask

    task automatic test_attenuation();
        int k;
        void'(model_write(8'hDF));
        pulse_we(8'hDF);
        wait_ready(k);
        void'(model_write(8'h03));
        pulse_we(8'h03);
        total++; if (att2 !== 4'h3) begin bad++; $display("FAIL att2_data got=%h exp=3", att2); end
        total++; if (freq2 !== m_freq[2]) begin bad++; $display("FAIL att_freq2_kept got=%h exp=%h", freq2, m_freq[2]); end
        wait_ready(k);
    endtask

    task automatic test_noise();
        int k;
        void'(model_write(8'hE5));
        pulse_we(8'hE5);
        total++; if (noise_ctrl !== 3'b101) begin bad++; $display("FAIL noise_latch got=%b exp=101", noise_ctrl); end
        total++; if (noise_rst !== 1'b1) begin bad++; $display("FAIL noise_pulse1 got=%b exp=1", noise_rst); end
        @(posedge clk); #1;
        total++; if (noise_rst !== 1'b0) begin bad++; $display("FAIL noise_pulse1_end got=%b exp=0", noise_rst); end
        wait_ready(k);
        void'(model_write(8'h02));
        pulse_we(8'h02);
        total++; if (noise_ctrl !== 3'b010) begin bad++; $display("FAIL noise_data got=%b exp=010", noise_ctrl); end
        total++; if (noise_rst !== 1'b1) begin bad++; $display("FAIL noise_pulse2 got=%b exp=1", noise_rst); end
        @(posedge clk); #1;
        total++; if (noise_rst !== 1'b0) begin bad++; $display("FAIL noise_pulse2_end got=%b exp=0", noise_rst); end
        wait_ready(k);
    endtask

    task automatic test_drop_busy();
        int k;
        void'(model_write(8'h95));
        pulse_we(8'h95);
        repeat (8) begin @(posedge clk); #1; end
        pulse_we(8'h9A);
        total++; if (att0 !== 4'h5) begin bad++; $display("FAIL drop_att0 got=%h exp=5", att0); end
        wait_ready(k);
        total++; if (k != int'(RC) - 10) begin bad++; $display("FAIL drop_ready_len got=%0d exp=%0d", k, RC - 10); end
        total++; if (att0 !== 4'h5) begin bad++; $display("FAIL drop_att0_after got=%h exp=5", att0); end
    endtask

    task automatic test_boundary();
        int k;
        void'(model_write(8'hB3));
        pulse_we(8'hB3);
        repeat (RC - 2) begin @(posedge clk); #1; end
        pulse_we(8'hB7);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL edge_ready got=%b exp=1", ready); end
        total++; if (att1 !== 4'h3) begin bad++; $display("FAIL edge_att1 got=%h exp=3", att1); end
        wait_ready(k);
    endtask

    task automatic test_hold_low();
        int k;
        void'(model_write(8'hD8));
        @(posedge clk); #1;
        data = 8'hD8;
        we_n = 1'b0;
        repeat (RC + 10) begin @(posedge clk); #1; end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL hold_ready got=%b exp=1", ready); end
        data = 8'h9C;
        repeat (5) begin @(posedge clk); #1; end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL hold_ready_late got=%b exp=1", ready); end
        total++; if (att2 !== 4'h8 || att0 !== m_att[0]) begin bad++; $display("FAIL hold_att got=%h/%h exp=8/%h", att2, att0, m_att[0]); end
        we_n = 1'b1;
        wait_ready(k);
    endtask

    task automatic test_random();
        int         k;
        bit         pulse;
        logic [7:0] d;
        for (int n = 0; n < 40; n++) begin
            d     = 8'($urandom_range(0, 255));
            pulse = model_write(d);
            pulse_we(d);
            total++; if (noise_rst !== pulse) begin bad++; $display("FAIL rnd_nrst byte=%h got=%b exp=%b", d, noise_rst, pulse); end
            for (int i = 0; i < 3; i++) begin
                total++; if (dut_freq[i] !== m_freq[i]) begin bad++; $display("FAIL rnd_freq%0d byte=%h got=%h exp=%h", i, d, dut_freq[i], m_freq[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                total++; if (dut_att[i] !== m_att[i]) begin bad++; $display("FAIL rnd_att%0d byte=%h got=%h exp=%h", i, d, dut_att[i], m_att[i]); end
            end
            total++; if (noise_ctrl !== m_nctrl) begin bad++; $display("FAIL rnd_nctrl byte=%h got=%b exp=%b", d, noise_ctrl, m_nctrl); end
            wait_ready(k);
            total++; if (k != int'(RC)) begin bad++; $display("FAIL rnd_ready_len byte=%h got=%0d exp=%0d", d, k, RC); end
        end
    endtask

    task automatic test_async_reset();
        int k;
        void'(model_write(8'hC6));
        pulse_we(8'hC6);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", ready); end
        total++; if ({freq0, freq1, freq2} !== 30'd0) begin bad++; $display("FAIL arst_freq got=%h %h %h exp=0", freq0, freq1, freq2); end
        total++; if ({att0, att1, att2, att3} !== 16'hFFFF) begin bad++; $display("FAIL arst_att got=%h exp=ffff", {att0, att1, att2, att3}); end
        total++; if (noise_ctrl !== 3'd0 || noise_rst !== 1'b0) begin bad++; $display("FAIL arst_noise got=%b/%b exp=000/0", noise_ctrl, noise_rst); end
        @(negedge clk);
        reset_n = 1'b1;
        // A data byte after reset targets tone 0 again
        void'(model_write(8'h25));
        pulse_we(8'h25);
        total++; if (freq0 !== m_freq[0]) begin bad++; $display("FAIL arst_latch_default got=%h exp=%h", freq0, m_freq[0]); end
        wait_ready(k);
    endtask

    initial begin
        reset_n = 1'b0;
        we_n    = 1'b1;
        data    = 8'h00;
        model_reset();
        #22;
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_tone();
        test_attenuation();
        test_noise();
        test_drop_busy();
        test_boundary();
        test_hold_low();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
